// File: rtl/branch_fetch_unit_pkg.sv
// Shared definitions for the branch/fetch front end.
//   br_op_t       : branch operation presented by the decoder each cycle
//   fetch_state_t : fetch FSM state
package branch_fetch_unit_pkg;

    typedef enum logic [2:0] {
        BR_NONE   = 3'd0,
        BR_REL_Z  = 3'd1,
        BR_REL_NZ = 3'd2,
        BR_ABS    = 3'd3,
        BR_CALL   = 3'd4,
        BR_RET    = 3'd5,
        BR_HALT   = 3'd6
    } br_op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/branch_fetch_unit_ras.sv
// Return-address stack: LIFO of DEPTH entries of W bits.
//   CLK, reset : clock, synchronous active-high reset (empties the stack)
//   clear      : empty the stack (restart)
//   push, din  : write din on top (caller guarantees !full, never with pop)
//   pop        : discard top entry (caller guarantees !empty)
//   top        : most recently pushed entry (valid when !empty)
//   full/empty : occupancy status
module ras_stack #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);
    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SP_W-1:0]  sp;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] top_idx;
    logic [W-1:0]     mem [1 << IDX_W];

    // sp counts entries; the next free slot is sp, the top is sp-1
    assign wr_idx  = IDX_W'(sp);
    assign top_idx = IDX_W'(sp - SP_W'(1));
    assign top     = mem[top_idx];
    assign full    = (sp == SP_W'(DEPTH));
    assign empty   = (sp == '0);

    always_ff @(posedge CLK) begin
        if (reset || clear) begin
            sp <= '0;
        end else if (push) begin
            mem[wr_idx] <= din;
            sp          <= sp + SP_W'(1);
        end else if (pop) begin
            sp <= sp - SP_W'(1);
        end
    end

endmodule

// File: rtl/branch_fetch_unit.sv
// Next-PC generator: PC register, fetch FSM, branch resolution and
// subroutine call/return through an internal return-address stack.
//   CLK, reset       : clock, synchronous active-high reset
//   start            : (re)start at START_ADDR, clears RAS and error flags
//   stall            : freeze PC, FSM and RAS for this cycle
//   br_op            : branch operation from the decoder
//   flag_zero        : registered ALU zero flag (REL_Z / REL_NZ condition)
//   tgt_off, tgt_abs : relative offset (two's complement) / absolute target
//   PC               : current instruction address
//   DONE, running    : program finished / FSM in RUN
//   ras_ovf, ras_unf : sticky RAS overflow / underflow
module branch_fetch_unit
    import branch_fetch_unit_pkg::*;
#(
    parameter int             PC_W       = 16,
    parameter int             RAS_DEPTH  = 4,
    parameter logic [PC_W-1:0] START_ADDR = '0,
    parameter logic [PC_W-1:0] END_ADDR   = '1
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            start,
    input  logic            stall,
    input  br_op_t          br_op,
    input  logic            flag_zero,
    input  logic [PC_W-1:0] tgt_off,
    input  logic [PC_W-1:0] tgt_abs,
    output logic [PC_W-1:0] PC,
    output logic            DONE,
    output logic            running,
    output logic            ras_ovf,
    output logic            ras_unf
);
    fetch_state_t    state, state_nxt;
    logic [PC_W-1:0] pc_nxt, pc_inc, pc_rel;
    logic            done_nxt, ovf_nxt, unf_nxt;
    logic            ras_push, ras_pop, ras_clr, ras_full, ras_empty;
    logic [PC_W-1:0] ras_top;

    assign pc_inc  = PC + PC_W'(1);
    assign pc_rel  = PC + tgt_off;  // modulo add == signed offset
    assign running = (state == ST_RUN);

    ras_stack #(.W(PC_W), .DEPTH(RAS_DEPTH)) u_ras (
        .CLK   (CLK),
        .reset (reset),
        .clear (ras_clr),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (pc_inc),
        .top   (ras_top),
        .full  (ras_full),
        .empty (ras_empty)
    );

    always_comb begin
        state_nxt = state;
        pc_nxt    = PC;
        done_nxt  = DONE;
        ovf_nxt   = ras_ovf;
        unf_nxt   = ras_unf;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        ras_clr   = 1'b0;
        if (start) begin
            state_nxt = ST_RUN;
            pc_nxt    = START_ADDR;
            done_nxt  = 1'b0;
            ovf_nxt   = 1'b0;
            unf_nxt   = 1'b0;
            ras_clr   = 1'b1;
        end else if (state == ST_RUN && !stall) begin
            if (PC == END_ADDR) begin
                state_nxt = ST_HALTED;
                done_nxt  = 1'b1;
            end else begin
                unique case (br_op)
                    BR_REL_Z:  pc_nxt = flag_zero  ? pc_rel : pc_inc;
                    BR_REL_NZ: pc_nxt = !flag_zero ? pc_rel : pc_inc;
                    BR_ABS:    pc_nxt = tgt_abs;
                    BR_CALL: begin
                        if (ras_full) begin
                            ovf_nxt   = 1'b1;
                            state_nxt = ST_HALTED;
                            done_nxt  = 1'b1;
                        end else begin
                            ras_push = 1'b1;
                            pc_nxt   = tgt_abs;
                        end
                    end
                    BR_RET: begin
                        if (ras_empty) begin
                            unf_nxt   = 1'b1;
                            state_nxt = ST_HALTED;
                            done_nxt  = 1'b1;
                        end else begin
                            ras_pop = 1'b1;
                            pc_nxt  = ras_top;
                        end
                    end
                    BR_HALT: begin
                        state_nxt = ST_HALTED;
                        done_nxt  = 1'b1;
                    end
                    default:   pc_nxt = pc_inc;  // NONE and unused encodings
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state   <= ST_IDLE;
            PC      <= '0;
            DONE    <= 1'b0;
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
        end else begin
            state   <= state_nxt;
            PC      <= pc_nxt;
            DONE    <= done_nxt;
            ras_ovf <= ovf_nxt;
            ras_unf <= unf_nxt;
        end
    end

endmodule
